// File: rtl/serial_frame_packer.sv
// rtl/serial_frame_packer.sv - byte framer: SOF, length, buffered payload, 16-bit checksum
// Input bytes land in a small show-ahead FIFO; every output is driven from a register.
module serial_frame_packer #(
  parameter int         DEPTH = 16,
  parameter logic [7:0] SOF   = 8'hA5
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [5:0]  i_RCC_BUFFER_LENGTH,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_overflow,
  output logic [15:0] o_checksum
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_SOF, S_LEN, S_PAYLOAD, S_CSUM_H, S_CSUM_L, S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_len;
  logic [7:0]    r_rcv_cnt;
  logic [7:0]    r_sent_cnt;
  logic [15:0]   r_checksum;
  logic          r_overflow;
  logic          r_tx_valid;
  logic [7:0]    r_tx_data;
  logic          r_busy;
  logic          r_done;

  logic          w_start;
  logic          w_hs;
  logic          w_pop;
  logic          w_in_window;
  logic          w_full;
  logic          w_push;
  logic          w_drop;
  logic [AW:0]   w_level_after_pop;
  logic [AW:0]   w_count_nxt;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [15:0]   w_checksum_nxt;
  logic          w_tx_valid_nxt;
  logic [7:0]    w_tx_data_nxt;

  assign w_start     = (r_state == S_IDLE) && i_start && !i_abort;
  assign w_hs        = r_tx_valid && i_tx_ready;
  assign w_pop       = w_hs && (r_state == S_PAYLOAD) && !i_abort;
  assign w_in_window = (r_state != S_IDLE) && (r_state != S_DONE) &&
                       (r_rcv_cnt < r_len) && !i_abort;
  assign w_full      = (r_count == (AW+1)'(DEPTH));
  // A full buffer still takes a byte when the head leaves in the same cycle.
  assign w_push      = w_in_window && i_byte_valid && (!w_full || w_pop);
  assign w_drop      = w_in_window && i_byte_valid && w_full && !w_pop;

  assign w_level_after_pop = r_count - (AW+1)'(w_pop);
  assign w_count_nxt       = w_level_after_pop + (AW+1)'(w_push);
  assign w_rd_ptr_nxt      = r_rd_ptr + AW'(w_pop);

  always_comb begin
    w_checksum_nxt = r_checksum;
    if (w_start) begin
      w_checksum_nxt = 16'h0000;
    end else if (w_push) begin
      w_checksum_nxt = r_checksum + {8'h00, i_byte};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (i_start) w_state_nxt = S_SOF;
        S_SOF:     if (w_hs) w_state_nxt = S_LEN;
        S_LEN:     if (w_hs) w_state_nxt = (r_len != 8'd0) ? S_PAYLOAD : S_CSUM_H;
        S_PAYLOAD: if (w_hs && (r_sent_cnt + 8'd1 == r_len)) w_state_nxt = S_CSUM_H;
        S_CSUM_H:  if (w_hs) w_state_nxt = S_CSUM_L;
        S_CSUM_L:  if (w_hs) w_state_nxt = S_DONE;
        S_DONE:    w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are precomputed for the next state so they can be registered.
  always_comb begin
    w_tx_valid_nxt = 1'b0;
    w_tx_data_nxt  = 8'h00;
    case (w_state_nxt)
      S_SOF: begin
        w_tx_valid_nxt = 1'b1;
        w_tx_data_nxt  = SOF;
      end
      S_LEN: begin
        w_tx_valid_nxt = 1'b1;
        w_tx_data_nxt  = r_len;
      end
      S_PAYLOAD: begin
        w_tx_valid_nxt = (w_count_nxt != '0);
        if (w_count_nxt != '0) begin
          w_tx_data_nxt = (w_level_after_pop == '0) ? i_byte : r_mem[w_rd_ptr_nxt];
        end
      end
      S_CSUM_H: begin
        w_tx_valid_nxt = 1'b1;
        w_tx_data_nxt  = w_checksum_nxt[15:8];
      end
      S_CSUM_L: begin
        w_tx_valid_nxt = 1'b1;
        w_tx_data_nxt  = w_checksum_nxt[7:0];
      end
      default: begin
        w_tx_valid_nxt = 1'b0;
        w_tx_data_nxt  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_byte;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_len      <= 8'd0;
      r_rcv_cnt  <= 8'd0;
      r_sent_cnt <= 8'd0;
      r_checksum <= 16'h0000;
      r_overflow <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_tx_valid <= w_tx_valid_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= (w_state_nxt == S_DONE);
      r_checksum <= w_checksum_nxt;
      if (w_start) begin
        r_len      <= {i_RCC_BUFFER_LENGTH, 2'b00};
        r_rcv_cnt  <= 8'd0;
        r_sent_cnt <= 8'd0;
        r_overflow <= 1'b0;
      end else begin
        if (w_push) r_rcv_cnt <= r_rcv_cnt + 8'd1;
        if (w_pop)  r_sent_cnt <= r_sent_cnt + 8'd1;
        if (w_drop) r_overflow <= 1'b1;
      end
      if (i_abort) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        r_rd_ptr <= w_rd_ptr_nxt;
        r_count  <= w_count_nxt;
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      end
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_overflow = r_overflow;
  assign o_checksum = r_checksum;

endmodule

// File: tb/tb_serial_frame_packer.sv
// tb/tb_serial_frame_packer.sv - self-checking bench for serial_frame_packer
// A queue-based frame model is compared with the DUT every cycle; literal frames pin the model.
module tb_serial_frame_packer;
  localparam int DEPTH = 16;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic [5:0]  i_len = 6'd0;
  logic [7:0]  i_byte = 8'h00;
  logic        i_byte_valid = 1'b0;
  logic        i_tx_ready = 1'b0;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        o_busy;
  logic        o_done;
  logic        o_overflow;
  logic [15:0] o_checksum;

  serial_frame_packer #(.DEPTH(DEPTH), .SOF(8'hA5)) dut (
    .CLK                 (CLK),
    .RESETn              (RESETn),
    .i_start             (i_start),
    .i_abort             (i_abort),
    .i_RCC_BUFFER_LENGTH (i_len),
    .i_byte              (i_byte),
    .i_byte_valid        (i_byte_valid),
    .o_tx_data           (o_tx_data),
    .o_tx_valid          (o_tx_valid),
    .i_tx_ready          (i_tx_ready),
    .o_busy              (o_busy),
    .o_done              (o_done),
    .o_overflow          (o_overflow),
    .o_checksum          (o_checksum)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Frame model: stream position m_pos walks SOF, LEN, payload, CSUM_H, CSUM_L.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_sum = 16'h0000;
  int          m_N = 0;
  int          m_pos = 0;
  logic [7:0]  m_payload[$];
  logic [7:0]  tx_log[$];
  logic [7:0]  exp_q[$];
  int          done_cnt = 0;
  logic        exp_valid;
  logic        hs;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  int          popped;

  function automatic logic [7:0] exp_byte(int pos);
    if (pos == 0) return 8'hA5;
    if (pos == 1) return 8'(m_N);
    if (pos < m_N + 2) return m_payload[pos-2];
    if (pos == m_N + 2) return m_sum[15:8];
    return m_sum[7:0];
  endfunction

  always @(negedge CLK) begin
    exp_valid = m_busy && (m_pos < m_N + 4) &&
                !(m_pos >= 2 && m_pos < m_N + 2 && m_payload.size() <= m_pos - 2);
    check("busy", 16'(o_busy), 16'(m_busy));
    check("done", 16'(o_done), 16'(m_done));
    check("overflow", 16'(o_overflow), 16'(m_ovf));
    check("checksum", o_checksum, m_sum);
    check("tx_valid", 16'(o_tx_valid), 16'(exp_valid));
    if (exp_valid) check("tx_data", {8'h00, o_tx_data}, {8'h00, exp_byte(m_pos)});
    if (prev_stall) check("hold", {8'h00, o_tx_data}, {8'h00, prev_data});
    if (o_done) done_cnt++;
    prev_stall = o_tx_valid && !i_tx_ready && RESETn && !i_abort;
    prev_data  = o_tx_data;

    hs = exp_valid && i_tx_ready;
    if (hs && RESETn && !i_abort) tx_log.push_back(o_tx_data);
    if (!RESETn) begin
      m_busy = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_sum = 16'h0000;
      m_N = 0; m_pos = 0; m_payload.delete();
    end else if (i_abort) begin
      m_busy = 1'b0; m_done = 1'b0; m_payload.delete();
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (i_start) begin
          m_N = 4 * int'(i_len); m_sum = 16'h0000; m_ovf = 1'b0;
          m_pos = 0; m_payload.delete(); m_busy = 1'b1;
        end
      end else if (m_pos == m_N + 4) begin
        m_busy = 1'b0;
      end else begin
        popped = (m_pos < 2) ? 0 : m_pos - 2;
        if (i_byte_valid && m_payload.size() < m_N) begin
          if ((m_payload.size() - popped < DEPTH) || (hs && m_pos >= 2 && m_pos < m_N + 2)) begin
            m_payload.push_back(i_byte);
            m_sum = m_sum + {8'h00, i_byte};
          end else begin
            m_ovf = 1'b1;
          end
        end
        if (hs) begin
          m_pos++;
          if (m_pos == m_N + 4) m_done = 1'b1;
        end
      end
    end
  end

  int         cyc = 0;
  int         rdy_mode = 0;
  logic [7:0] feed_q[$];
  int         done_before;

  task automatic step();
    if (feed_q.size() > 0) begin
      i_byte_valid = 1'b1;
      i_byte = feed_q.pop_front();
    end else begin
      i_byte_valid = 1'b0;
    end
    case (rdy_mode)
      1:       i_tx_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      2:       i_tx_ready = (cyc <= 1);
      default: i_tx_ready = 1'b1;
    endcase
    @(posedge CLK);
    #1;
    i_start = 1'b0;
    i_abort = 1'b0;
    cyc++;
  endtask

  task automatic start_frame(input logic [5:0] len);
    i_len = len;
    i_start = 1'b1;
    cyc = 0;
    step();
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while (o_done !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    check({name, "_done_seen"}, 16'(o_done), 16'd1);
    step();
  endtask

  task automatic check_log(input string name);
    check({name, "_len"}, 16'(tx_log.size()), 16'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
      check({name, "_byte"}, {8'h00, tx_log[i]}, {8'h00, exp_q[i]});
    tx_log.delete();
    exp_q.delete();
  endtask

  initial begin
    RESETn = 1'b0;
    repeat (3) step();
    RESETn = 1'b1;
    step();
    check("rst_valid", 16'(o_tx_valid), 16'd0);
    check("rst_data", {8'h00, o_tx_data}, 16'h0000);
    check("rst_busy", 16'(o_busy), 16'd0);
    check("rst_ovf", 16'(o_overflow), 16'd0);
    check("rst_csum", o_checksum, 16'h0000);

    // basic frame
    rdy_mode = 0;
    done_before = done_cnt;
    start_frame(6'd1);
    check("sof_latency_valid", 16'(o_tx_valid), 16'd1);
    check("sof_latency_data", {8'h00, o_tx_data}, 16'h00A5);
    feed_q = {8'h11, 8'h22, 8'h33, 8'h44};
    wait_done(40, "basic");
    exp_q = {8'hA5, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'hAA};
    check_log("basic");
    check("basic_csum", o_checksum, 16'h00AA);
    check("basic_done_once", 16'(done_cnt - done_before), 16'd1);

    // zero length
    done_before = done_cnt;
    start_frame(6'd0);
    feed_q = {8'h77, 8'h78, 8'h79};
    wait_done(20, "zero");
    exp_q = {8'hA5, 8'h00, 8'h00, 8'h00};
    check_log("zero");
    check("zero_csum", o_checksum, 16'h0000);
    check("zero_done_once", 16'(done_cnt - done_before), 16'd1);

    // backpressure
    rdy_mode = 1;
    start_frame(6'd2);
    feed_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    wait_done(80, "bp");
    exp_q = {8'hA5, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00, 8'h24};
    check_log("bp");
    check("bp_csum", o_checksum, 16'h0024);
    check("bp_no_ovf", 16'(o_overflow), 16'd0);

    // overflow then abort
    rdy_mode = 2;
    start_frame(6'd8);
    for (int i = 1; i <= 20; i++) feed_q.push_back(8'(i));
    repeat (22) step();
    check("ovf_flag", 16'(o_overflow), 16'd1);
    check("ovf_csum", o_checksum, 16'h0088);
    check("ovf_busy", 16'(o_busy), 16'd1);
    i_abort = 1'b1;
    step();
    check("abort_busy", 16'(o_busy), 16'd0);
    check("abort_valid", 16'(o_tx_valid), 16'd0);
    check("abort_csum_kept", o_checksum, 16'h0088);
    check("abort_ovf_kept", 16'(o_overflow), 16'd1);
    tx_log.delete();

    // extra bytes and ignored start
    rdy_mode = 0;
    done_before = done_cnt;
    start_frame(6'd1);
    feed_q = {8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    step();
    step();
    i_len = 6'd2;
    i_start = 1'b1;
    step();
    wait_done(40, "extra");
    exp_q = {8'hA5, 8'h04, 8'h11, 8'h12, 8'h13, 8'h14, 8'h00, 8'h4A};
    check_log("extra");
    check("extra_csum", o_checksum, 16'h004A);
    check("extra_done_once", 16'(done_cnt - done_before), 16'd1);

    // reset mid-payload, then a clean frame
    start_frame(6'd2);
    feed_q = {8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
    repeat (5) step();
    check("mid_busy", 16'(o_busy), 16'd1);
    feed_q.delete();
    RESETn = 1'b0;
    step();
    RESETn = 1'b1;
    check("rst2_valid", 16'(o_tx_valid), 16'd0);
    check("rst2_data", {8'h00, o_tx_data}, 16'h0000);
    check("rst2_busy", 16'(o_busy), 16'd0);
    check("rst2_done", 16'(o_done), 16'd0);
    check("rst2_ovf", 16'(o_overflow), 16'd0);
    check("rst2_csum", o_checksum, 16'h0000);
    tx_log.delete();
    step();
    start_frame(6'd1);
    feed_q = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    wait_done(40, "post_rst");
    exp_q = {8'hA5, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h03, 8'h0E};
    check_log("post_rst");
    check("post_rst_csum", o_checksum, 16'h030E);

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_frame_packer.md
# serial_frame_packer

Byte-stream framer that sits directly downstream of the FIFO reader/serializer on the slow clock domain. It accepts the serialized 8-bit DMA read data and buffers it in a small internal byte FIFO. It emits a framed stream (start byte, length byte, payload, 16-bit checksum) on a ready/valid output port. One frame corresponds to one DMA command of `i_RCC_BUFFER_LENGTH` 32-bit words.

## Interface
Parameters:
- `DEPTH`, 16: internal byte buffer depth; power of two, ≥4.
- `SOF`, 8'hA5: start-of-frame byte.

Ports:
- `CLK` in 1: single clock (slow domain).
- `RESETn` in 1: reset, synchronous, active-low.
- `i_start` in 1: one-cycle pulse that starts a frame; sampled only in IDLE.
- `i_abort` in 1: returns to IDLE, flushes the buffer, no `o_done`.
- `i_RCC_BUFFER_LENGTH` in 6: frame length in words, latched at `i_start`.
- `i_byte` in 8: serialized data byte.
- `i_byte_valid` in 1: `i_byte` qualifier; the source has no backpressure.
- `o_tx_data` out 8: framed output byte.
- `o_tx_valid` out 1: `o_tx_data` valid.
- `i_tx_ready` in 1: sink accepts the byte when `o_tx_valid && i_tx_ready` at a rising edge.
- `o_busy` out 1: high in every state except IDLE.
- `o_done` out 1: one-cycle pulse after the last checksum byte is accepted.
- `o_overflow` out 1: sticky; an input byte was dropped because the buffer was full.
- `o_checksum` out 16: running checksum; holds the final value after the frame.

## Operation
- States: IDLE, SOF, LEN, PAYLOAD, CSUM_H, CSUM_L, DONE.
- **IDLE**
  - On `i_start`, latch `N = 4*i_RCC_BUFFER_LENGTH` (8 bits, max 252).
  - Clear the received count, sent count, `o_checksum` and `o_overflow`.
  - Go to SOF.
  - `i_start` outside IDLE is ignored.
- **SOF**: drive `SOF`, hold until handshake, then go to LEN.
- **LEN**: drive `N`, hold until handshake.
  - Next state is PAYLOAD if `N != 0`, otherwise CSUM_H.
- **Input acceptance**
  - Applies in any state except IDLE and DONE, while received count < `N`.
  - An `i_byte_valid` byte is written to the buffer, the received count is incremented, and `o_checksum += {8'h00, i_byte}` (mod 2^16).
  - Bytes arriving in IDLE/DONE, or after `N` bytes have been received, are ignored silently.
- **Full buffer**
  - If the buffer is full and no pop occurs in the same cycle, the byte is dropped.
  - A dropped byte does not count and does not touch the checksum; `o_overflow` is set.
  - Write while full with a simultaneous pop is accepted; the count is unchanged.
- **PAYLOAD**
  - `o_tx_data` is the buffer head (show-ahead); `o_tx_valid` = buffer non-empty.
  - Each handshake pops one byte and increments the sent count.
  - When sent count reaches `N`, go to CSUM_H.
  - A frame with dropped bytes stalls in PAYLOAD until `i_abort` or reset.
- **CSUM_H / CSUM_L**: drive `o_checksum[15:8]`, then `o_checksum[7:0]`, each held until handshake.
- **DONE**: `o_done` high for one cycle, then IDLE.
- **Abort and reset**
  - `i_abort` has priority over every transition.
  - Next cycle: IDLE, buffer empty, `o_tx_valid` = 0.
  - `o_checksum` and `o_overflow` keep their values.
  - `RESETn` low mid-frame gives the same result, with all outputs at reset values.

## Timing
- **Reset values**: `o_tx_data` = 0, `o_tx_valid` = 0, `o_busy` = 0, `o_done` = 0, `o_overflow` = 0, `o_checksum` = 0, buffer empty.
- **Registered outputs**: all outputs come from registers; no combinational path from `i_tx_ready` to `o_tx_valid`/`o_tx_data`.
- **Latency**
  - `i_start` at cycle 0 → SOF valid at cycle 1.
  - With `i_tx_ready` held high: LEN at cycle 2, first payload byte no earlier than cycle 3.
  - A byte written at cycle k is visible at the head at cycle k+1.
- **Output hold rule**: while `o_tx_valid` = 1 and `i_tx_ready` = 0, `o_tx_data` is stable.
- **Throughput**: one byte per cycle, sustained when `i_tx_ready` = 1 and data is available.
- **Checksum timing**: `o_checksum` updates the cycle after each accepted byte and is final before CSUM_H is entered.

## Test plan
- **Basic frame**
  - Stimulus: len=1, bytes 11,22,33,44 one per cycle, ready=1.
  - Required: A5 04 11 22 33 44 00 AA; `o_done` pulses once; `o_checksum` = 0x00AA.
- **Zero length**
  - Stimulus: len=0.
  - Required: A5 00 00 00, then `o_done`; no payload state; bytes offered meanwhile are ignored.
- **Backpressure**
  - Stimulus: len=2, bytes 01..08, `i_tx_ready` toggling 1,0,0,1.
  - Required: `o_tx_data` stable whenever stalled; stream A5 08 01..08 00 24; no overflow.
- **Overflow**
  - Stimulus: DEPTH=16, len=8, ready=0 after SOF, 20 bytes offered.
  - Required: 16 stored, `o_overflow` = 1, `o_checksum` covers only the 16 stored bytes.
  - Then `i_abort`: IDLE next cycle, `o_busy` = 0, `o_tx_valid` = 0.
- **Extra bytes and ignored start**
  - Stimulus: len=1 with 6 bytes offered; `i_start` pulsed mid-frame.
  - Required: only the first 4 bytes are framed; the second `i_start` has no effect.
- **Reset mid-payload**
  - Stimulus: `RESETn` low for 1 cycle during PAYLOAD.
  - Required: all outputs at reset values; the next `i_start` yields a clean frame.
